// File: rtl/pipe_adder.sv
// pipe_adder: pipelined add/subtract with valid/ready, carry chain cut into STAGES chunks.
// Optional PIPE_ADDER_SAT_EN clamps subtract results at zero.
module pipe_adder #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum
);
   localparam int C = (WIDTH + STAGES - 1) / STAGES;
   localparam int L = STAGES - 1;
   logic              adv;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  r_q [STAGES];
   logic [WIDTH-1:0]  a_d [STAGES];
   logic [WIDTH-1:0]  b_d [STAGES];
   logic [WIDTH-1:0]  r_d [STAGES];
   logic [STAGES-1:0] c_q, s_q, v_q, c_d, s_d, v_d;
   logic [WIDTH:0]    sum_q, sum_d;
   assign adv       = out_ready || !out_valid;
   assign in_ready  = adv;
   assign out_valid = v_q[L];
   assign sum       = sum_q;
   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      localparam int LO = g * C;
      localparam int HI = (((g + 1) * C > WIDTH) ? WIDTH : (g + 1) * C) - 1;
      logic [WIDTH-1:0] ai, bi, ri;
      logic             ci, si, vi;
      if (g == 0) begin : g_first
         assign ai = a;
         assign bi = sub ? ~b : b;
         assign ri = '0;
         assign ci = sub;
         assign si = sub;
         assign vi = in_valid;
      end else begin : g_next
         assign ai = a_q[g-1];
         assign bi = b_q[g-1];
         assign ri = r_q[g-1];
         assign ci = c_q[g-1];
         assign si = s_q[g-1];
         assign vi = v_q[g-1];
      end
      // Stages beyond the last populated chunk only forward the carry.
      if (LO < WIDTH) begin : g_chunk
         logic [HI-LO+1:0] t;
         logic [WIDTH-1:0] rn;
         assign t = {1'b0, ai[HI:LO]} + {1'b0, bi[HI:LO]} + {{(HI-LO+1){1'b0}}, ci};
         always_comb begin
            rn        = ri;
            rn[HI:LO] = t[HI-LO:0];
         end
         assign r_d[g] = rn;
         assign c_d[g] = t[HI-LO+1];
      end else begin : g_pass
         assign r_d[g] = ri;
         assign c_d[g] = ci;
      end
      assign a_d[g] = ai;
      assign b_d[g] = bi;
      assign s_d[g] = si;
      assign v_d[g] = vi;
   end
`ifdef PIPE_ADDER_SAT_EN
   assign sum_d = (s_d[L] && !c_d[L]) ? '0 : {c_d[L] ^ s_d[L], r_d[L]};
`else
   assign sum_d = {c_d[L] ^ s_d[L], r_d[L]};
`endif
   // Data registers load only with valid data so the output holds across bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q   <= '0;
         sum_q <= '0;
      end else if (adv) begin
         v_q <= v_d;
         for (int k = 0; k < STAGES; k++) begin
            if (v_d[k]) begin
               a_q[k] <= a_d[k];
               b_q[k] <= b_d[k];
               r_q[k] <= r_d[k];
               c_q[k] <= c_d[k];
               s_q[k] <= s_d[k];
            end
         end
         if (v_d[L]) sum_q <= sum_d;
      end
   end
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed and randomised-stream checks of pipe_adder (WIDTH=4; STAGES=2, 1, 4).
module tb_pipe_adder;
   logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, sub = 1'b0, out_ready = 1'b1;
   logic [3:0] a = '0, b = '0;
   logic       in_ready, out_valid, in_ready_1, out_valid_1, in_ready_4, out_valid_4;
   logic [4:0] sum, sum_1, sum_4;
   int         checks = 0, failures = 0;
   pipe_adder #(.WIDTH(4), .STAGES(2)) dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum));
   pipe_adder #(.WIDTH(4), .STAGES(1)) u_s1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid_1), .out_ready(out_ready), .sum(sum_1));
   pipe_adder #(.WIDTH(4), .STAGES(4)) u_s4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_4),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid_4), .out_ready(out_ready), .sum(sum_4));
   always #5 clk = ~clk;
   function automatic logic [4:0] model(logic [3:0] x, logic [3:0] y, logic s);
`ifdef PIPE_ADDER_SAT_EN
      if (s && x < y) return 5'h00;
`endif
      return s ? {x < y, 4'(x - y)} : {1'b0, x} + {1'b0, y};
   endfunction
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b1; a = 4'h7; b = 4'h2;
      repeat (2) begin
         tick;
         checks += 3;
         if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
         if (sum !== 5'h00) begin failures++; $display("FAIL reset_sum got=%h exp=00", sum); end
         if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      end
      rst = 1'b0; in_valid = 1'b0;
      repeat (4) begin
         tick;
         checks++;
         if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_release_valid got=%b exp=0", out_valid); end
      end
   endtask
   task automatic test_latency;
      out_ready = 1'b1; in_valid = 1'b1; a = 4'h0; b = 4'h0; sub = 1'b0;
      tick;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", out_valid); end
      tick;
      checks += 2;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL latency_valid got=%b exp=1", out_valid); end
      if (sum !== 5'h00) begin failures++; $display("FAIL latency_sum got=%h exp=00", sum); end
      tick;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_single got=%b exp=0", out_valid); end
   endtask
   task automatic test_back_to_back(input logic [3:0] a0, input logic [3:0] b0, input logic s0, input logic [4:0] e0,
                                    input logic [3:0] a1, input logic [3:0] b1, input logic s1, input logic [4:0] e1);
      out_ready = 1'b1; in_valid = 1'b1; a = a0; b = b0; sub = s0;
      tick;
      a = a1; b = b1; sub = s1;
      tick;
      in_valid = 1'b0;
      checks += 2;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_first_valid got=%b exp=1", out_valid); end
      if (sum !== e0) begin failures++; $display("FAIL b2b_first_sum got=%h exp=%h", sum, e0); end
      tick;
      checks += 2;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_second_valid got=%b exp=1", out_valid); end
      if (sum !== e1) begin failures++; $display("FAIL b2b_second_sum got=%h exp=%h", sum, e1); end
      tick;
      checks += 2;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
      if (sum !== e1) begin failures++; $display("FAIL b2b_hold_sum got=%h exp=%h", sum, e1); end
   endtask
   task automatic test_carry;
      test_back_to_back(4'hF, 4'hF, 1'b0, 5'h1E, 4'hF, 4'h1, 1'b0, 5'h10);
   endtask
   task automatic test_sub;
`ifdef PIPE_ADDER_SAT_EN
      test_back_to_back(4'h3, 4'h5, 1'b1, 5'h00, 4'h5, 4'h3, 1'b1, 5'h02);
`else
      test_back_to_back(4'h3, 4'h5, 1'b1, 5'h1E, 4'h5, 4'h3, 1'b1, 5'h02);
`endif
   endtask
   task automatic test_stream;
      logic [4:0] q[$];
      logic [4:0] held, exp;
      logic       held_v;
      logic [3:0] ra, rb;
      int         sent, got, cyc;
      sent = 0; got = 0; cyc = 0; held_v = 1'b0; held = '0;
      while (got < 400 && cyc < 4000) begin
         if (held_v) begin
            checks += 2;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid got=%b exp=1", out_valid); end
            if (sum !== held) begin failures++; $display("FAIL stall_sum got=%h exp=%h", sum, held); end
         end
         ra = 4'($urandom); rb = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid = (sent < 400) && ($urandom_range(0, 3) != 0);
         sub = 1'($urandom_range(0, 1));
         case (sent % 4)
            0: begin a = ra; b = rb; end
            1: begin a = rb[0] ? 4'h0 : ra; b = rb[0] ? rb : 4'h0; end
            2: begin a = rb[0] ? 4'hF : ra; b = rb[0] ? rb : 4'hF; end
            default: begin a = rb[0] ? 4'hF : 4'h1; b = rb[0] ? 4'h1 : 4'hF; end
         endcase
         #1;
         checks++;
         if (in_ready !== (out_ready || !out_valid)) begin
            failures++; $display("FAIL stream_in_ready got=%b exp=%b", in_ready, out_ready || !out_valid);
         end
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               failures++; $display("FAIL stream_extra got=%h exp=none", sum);
            end else begin
               exp = q.pop_front();
               if (sum !== exp) begin failures++; $display("FAIL stream_sum got=%h exp=%h item=%0d", sum, exp, got); end
            end
            got++;
         end
         held_v = out_valid && !out_ready;
         held = sum;
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, sub));
            sent++;
         end
         tick;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++;
      if (got != 400) begin failures++; $display("FAIL stream_timeout got=%0d exp=400", got); end
   endtask
   task automatic test_reset_flight;
      out_ready = 1'b1; in_valid = 1'b1; sub = 1'b0; a = 4'h1; b = 4'h2;
      tick;
      a = 4'h3; b = 4'h4;
      tick;
      rst = 1'b1; in_valid = 1'b0;
      tick;
      rst = 1'b0;
      checks += 4;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL flight_s2_valid got=%b exp=0", out_valid); end
      if (sum !== 5'h00) begin failures++; $display("FAIL flight_s2_sum got=%h exp=00", sum); end
      if (out_valid_1 !== 1'b0) begin failures++; $display("FAIL flight_s1_valid got=%b exp=0", out_valid_1); end
      if (out_valid_4 !== 1'b0) begin failures++; $display("FAIL flight_s4_valid got=%b exp=0", out_valid_4); end
      repeat (6) begin
         tick;
         checks++;
         if ({out_valid, out_valid_1, out_valid_4} !== 3'b000) begin
            failures++; $display("FAIL flight_ghost got=%b exp=000", {out_valid, out_valid_1, out_valid_4});
         end
      end
      in_valid = 1'b1; a = 4'h6; b = 4'h7;
      for (int k = 1; k <= 4; k++) begin
         tick;
         in_valid = 1'b0;
         checks += 3;
         if (out_valid !== (k == 2)) begin failures++; $display("FAIL flight_s2_lat k=%0d got=%b", k, out_valid); end
         if (out_valid_1 !== (k == 1)) begin failures++; $display("FAIL flight_s1_lat k=%0d got=%b", k, out_valid_1); end
         if (out_valid_4 !== (k == 4)) begin failures++; $display("FAIL flight_s4_lat k=%0d got=%b", k, out_valid_4); end
         if (k == 2) begin
            checks++;
            if (sum !== 5'h0D) begin failures++; $display("FAIL flight_s2_sum got=%h exp=0d", sum); end
         end
         if (k == 1) begin
            checks++;
            if (sum_1 !== 5'h0D) begin failures++; $display("FAIL flight_s1_sum got=%h exp=0d", sum_1); end
         end
         if (k == 4) begin
            checks++;
            if (sum_4 !== 5'h0D) begin failures++; $display("FAIL flight_s4_sum got=%h exp=0d", sum_4); end
         end
      end
   endtask
   initial begin
      test_reset;
      test_latency;
      test_carry;
      test_sub;
      test_stream;
      test_reset_flight;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
